// File: rtl/mtncl_wave_sched_if.sv
// ==== mtncl_wave_sched_if : requester + MTNCL stage bundle for mtncl_wave_sched -- rev 1.0 ====
`default_nettype none
interface mtncl_wave_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      dout;
  logic [2*WIDTH-1:0]    dr_out;
  logic                  sleep_out;
  logic                  ko_in;
  logic [2*WIDTH-1:0]    res_dr;
  logic                  busy;
  logic                  err_timeout;

  modport master (
    input  req, din, ko_in, res_dr,
    output gnt, done, dout, dr_out, sleep_out, busy, err_timeout
  );

  modport slave (
    output req, din, ko_in, res_dr,
    input  gnt, done, dout, dr_out, sleep_out, busy, err_timeout
  );
endinterface
`default_nettype wire

// File: rtl/mtncl_wave_sched.sv
// ==== mtncl_wave_sched : round-robin scheduler sharing one MTNCL stage (option: MTNCL_DR_CHECK_EN) -- rev 1.0 ====
`default_nettype none
module mtncl_wave_sched #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mtncl_wave_sched_if.master bus
`ifdef MTNCL_DR_CHECK_EN
  ,
  output logic               dr_err
`endif
);
  localparam int          PW   = $clog2(NREQ);
  localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RET  = 2'd2,
    S_NULL = 2'd3
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [PW-1:0]          r_ptr;
  logic [15:0]            r_timer;
  logic [NREQ-1:0]        r_gnt;
  logic [NREQ-1:0]        r_done;
  logic [WIDTH-1:0]       r_dout;
  logic [2*WIDTH-1:0]     r_dr;
  logic                   r_sleep;
  logic                   r_busy;
  logic                   r_err;

  logic                   w_ko_s;
  logic                   w_found;
  logic [PW-1:0]          w_idx;
  logic [PW-1:0]          w_ptr_nxt;
  logic [PW:0]            w_sum;
  logic [WIDTH-1:0]       w_din_sel;
  logic [WIDTH-1:0]       w_res;
  logic [2*WIDTH-1:0]     w_enc;
`ifdef MTNCL_DR_CHECK_EN
  logic                   w_bad;
  logic                   r_dr_err;
`else
  logic                   w_unused_rail0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], bus.ko_in};
  end
  assign w_ko_s = r_sync[SYNC_STAGES-1];

  // Scan from the pointer downward so the closest requester at or after ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(NREQ)) w_sum = w_sum - (PW+1)'(NREQ);
      if (bus.req[w_sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_sum[PW-1:0];
      end
    end
  end

  assign w_ptr_nxt = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
  assign w_din_sel = bus.din[w_idx*WIDTH +: WIDTH];

  always_comb begin
    w_enc = '0;
    w_res = '0;
`ifdef MTNCL_DR_CHECK_EN
    w_bad = 1'b0;
`endif
    for (int b = 0; b < WIDTH; b++) begin
      w_enc[2*b+1] = w_din_sel[b];
      w_enc[2*b]   = ~w_din_sel[b];
      w_res[b]     = bus.res_dr[2*b+1];
`ifdef MTNCL_DR_CHECK_EN
      if (bus.res_dr[2*b+1] == bus.res_dr[2*b]) begin
        w_res[b] = 1'b0;
        w_bad    = 1'b1;
      end
`endif
    end
  end

`ifndef MTNCL_DR_CHECK_EN
  assign w_unused_rail0 = ^bus.res_dr;
`endif

  // r_dr doubles as the operand register: the encoded din slice is frozen at grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_timer  <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_dout   <= '0;
      r_dr     <= '0;
      r_sleep  <= 1'b1;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
`ifdef MTNCL_DR_CHECK_EN
      r_dr_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found && !w_ko_s) begin
            r_gnt   <= NREQ'(1) << w_idx;
            r_dr    <= w_enc;
            r_sleep <= 1'b0;
            r_busy  <= 1'b1;
            r_timer <= '0;
            r_ptr   <= w_ptr_nxt;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_ko_s) begin
            r_dout  <= w_res;
            r_done  <= r_gnt;
            r_state <= S_RET;
`ifdef MTNCL_DR_CHECK_EN
            if (w_bad) r_dr_err <= 1'b1;
`endif
          end else if (r_timer == TMAX) begin
            r_err   <= 1'b1;
            r_dout  <= '0;
            r_done  <= r_gnt;
            r_state <= S_RET;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        S_RET: begin
          r_done  <= '0;
          r_sleep <= 1'b1;
          r_dr    <= '0;
          r_timer <= '0;
          r_state <= S_NULL;
        end
        S_NULL: begin
          if (!w_ko_s || r_timer == TMAX) begin
            if (w_ko_s) r_err <= 1'b1;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.done        = r_done;
  assign bus.dout        = r_dout;
  assign bus.dr_out      = r_dr;
  assign bus.sleep_out   = r_sleep;
  assign bus.busy        = r_busy;
  assign bus.err_timeout = r_err;
`ifdef MTNCL_DR_CHECK_EN
  assign dr_err          = r_dr_err;
`endif
endmodule
`default_nettype wire

// File: tb/tb_mtncl_wave_sched.sv
// ==== tb_mtncl_wave_sched : bench for mtncl_wave_sched with a behavioural MTNCL stage -- rev 1.0 ====
`default_nettype none
module tb_mtncl_wave_sched;
  localparam int NREQ = 4, WIDTH = 8, SYNC = 2, TOUT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mtncl_wave_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

`ifdef MTNCL_DR_CHECK_EN
  logic dr_err;
`endif

  mtncl_wave_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .TIMEOUT(TOUT)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus)
`ifdef MTNCL_DR_CHECK_EN
    ,
    .dr_err (dr_err)
`endif
  );

  int checks = 0;
  int errors = 0;
  int mptr   = 0;

  // Stage model: ko follows the wavefront kind after stg_dly extra cycles; mode 1/2 pin ko low/high.
  int          stg_mode = 0;
  int          stg_dly  = 1;
  int          st_cnt   = 0;
  logic [15:0] corrupt  = '0;

  always @(posedge clk) begin
    if (rst && stg_mode == 0) begin
      bus.ko_in <= 1'b0;
      st_cnt    <= 0;
    end else if (stg_mode == 1) bus.ko_in <= 1'b0;
    else if (stg_mode == 2) bus.ko_in <= 1'b1;
    else if (bus.ko_in != ~bus.sleep_out) begin
      if (st_cnt >= stg_dly) begin
        bus.ko_in <= ~bus.sleep_out;
        st_cnt    <= 0;
      end else st_cnt <= st_cnt + 1;
    end else st_cnt <= 0;
  end

  assign bus.res_dr = bus.sleep_out ? 16'h0000 : (bus.dr_out | corrupt);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expire(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done != '0) chk("done_with_gnt", 32'(bus.done & ~bus.gnt), 32'd0);
    if (!rst && bus.gnt != '0)  chk("gnt_onehot", 32'($onehot(bus.gnt)), 32'd1);
  end

  function automatic logic [15:0] dual_rail(input logic [7:0] x);
    logic [15:0] r = '0;
    for (int b = 0; b < 8; b++) r[2*b +: 2] = x[b] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  function automatic int oh2i(input logic [3:0] g);
    for (int i = 0; i < NREQ; i++) if (g[i]) return i;
    return 0;
  endfunction

  // which: 0 = any grant, 1 = any done, 2 = not busy
  task automatic wait_for(input int which, input string nm);
    for (int n = 0; n < 200; n++) begin
      if ((which == 0 && bus.gnt != '0) || (which == 1 && bus.done != '0) ||
          (which == 2 && !bus.busy)) return;
      @(negedge clk);
    end
    expire(nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    mptr = 0;
    @(negedge clk);
  endtask

  task automatic run_txn(input logic [3:0] reqv, input logic [31:0] dins, input int dly,
                         input bit drop, input logic [3:0] exp_g, input logic [7:0] exp_d,
                         input logic [15:0] exp_dr);
    stg_dly = dly;
    bus.req = reqv;
    bus.din = dins;
    wait_for(0, "gnt_wait");
    chk("gnt", 32'(bus.gnt), 32'(exp_g));
    chk("dr_out_data", 32'(bus.dr_out), 32'(exp_dr));
    chk("sleep_data", 32'(bus.sleep_out), 32'd0);
    bus.din = $urandom;
    if (drop) bus.req = '0;
    wait_for(1, "done_wait");
    chk("done", 32'(bus.done), 32'(exp_g));
    chk("dout", 32'(bus.dout), 32'(exp_d));
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd0);
    chk("sleep_null", 32'(bus.sleep_out), 32'd1);
    chk("dr_out_null", 32'(bus.dr_out), 32'd0);
    wait_for(2, "idle_wait");
    chk("gnt_clear", 32'(bus.gnt), 32'd0);
    bus.req = '0;
    mptr = (oh2i(exp_g) + 1) % NREQ;
  endtask

  typedef struct {
    bit          rst_before;
    logic [3:0]  req;
    logic [31:0] din;
    int          dly;
    logic [3:0]  exp_g;
    logic [7:0]  exp_d;
    logic [15:0] exp_dr;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int          n;
    int          g;
    logic [3:0]  rv;
    logic [31:0] dv;
    logic [7:0]  ed;

    tbl[0] = '{1'b0, 4'b0001, 32'h0000_00A5, 2, 4'b0001, 8'hA5, 16'h9966};
    tbl[1] = '{1'b1, 4'b1111, 32'h4433_2211, 0, 4'b0001, 8'h11, 16'h0};
    tbl[2] = '{1'b0, 4'b1111, 32'h4433_2211, 1, 4'b0010, 8'h22, 16'h0};
    tbl[3] = '{1'b0, 4'b1111, 32'h4433_2211, 3, 4'b0100, 8'h33, 16'h0};
    tbl[4] = '{1'b0, 4'b1111, 32'h4433_2211, 2, 4'b1000, 8'h44, 16'h0};
    tbl[5] = '{1'b0, 4'b1001, 32'h4433_2211, 0, 4'b0001, 8'h11, 16'h0};
    tbl[6] = '{1'b0, 4'b1001, 32'h4433_2211, 1, 4'b1000, 8'h44, 16'h0};
    tbl[7] = '{1'b0, 4'b1001, 32'h4433_2211, 2, 4'b0001, 8'h11, 16'h0};
    for (int i = 1; i < 8; i++) tbl[i].exp_dr = dual_rail(tbl[i].exp_d);

    bus.req = '0;
    bus.din = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_dr_out", 32'(bus.dr_out), 32'd0);
    chk("rst_sleep", 32'(bus.sleep_out), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err_timeout), 32'd0);
`ifdef MTNCL_DR_CHECK_EN
    chk("rst_dr_err", 32'(dr_err), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rst_before) do_reset();
      run_txn(tbl[i].req, tbl[i].din, tbl[i].dly, 1'b0, tbl[i].exp_g, tbl[i].exp_d, tbl[i].exp_dr);
    end

    // DATA timeout: ko never rises, so DATA lasts exactly TOUT cycles.
    stg_mode = 1;
    g        = pick(4'b0100, mptr);
    bus.req  = 4'b0100;
    bus.din  = 32'h00CC_0000;
    wait_for(0, "to_gnt_wait");
    chk("to_gnt", 32'(bus.gnt), 32'(4'b0001 << g));
    n = 0;
    while (bus.done == '0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("to_data_cycles", n, TOUT);
    chk("to_done", 32'(bus.done), 32'(4'b0001 << g));
    chk("to_dout", 32'(bus.dout), 32'd0);
    chk("to_err", 32'(bus.err_timeout), 32'd1);
    @(negedge clk);
    chk("to_sleep", 32'(bus.sleep_out), 32'd1);
    stg_mode = 0;
    bus.req  = '0;
    wait_for(2, "to_idle_wait");
    mptr = (g + 1) % NREQ;

    // NULL stall: ko stuck high after the data wavefront.
    do_reset();
    stg_dly = 1;
    bus.req = 4'b0001;
    bus.din = 32'h0000_005A;
    wait_for(1, "ns_done_wait");
    chk("ns_dout", 32'(bus.dout), 32'h5A);
    stg_mode = 2;
    wait_for(2, "ns_idle_wait");
    chk("ns_err", 32'(bus.err_timeout), 32'd1);
    chk("ns_gnt_clear", 32'(bus.gnt), 32'd0);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.gnt != '0) n++;
    end
    chk("ns_blocked", n, 0);
    stg_mode = 0;
    mptr     = 1;
    g        = pick(4'b0011, mptr);
    run_txn(4'b0011, 32'h0000_C3B7, 1, 1'b0, 4'(1 << g), 8'hC3, dual_rail(8'hC3));

    // Asynchronous reset while waiting in DATA.
    stg_mode = 1;
    bus.req  = 4'b0010;
    bus.din  = 32'h0000_7700;
    wait_for(0, "ar_gnt_wait");
    repeat (3) @(negedge clk);
    chk("ar_err_before", 32'(bus.err_timeout), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_sleep", 32'(bus.sleep_out), 32'd1);
    chk("ar_dr_out", 32'(bus.dr_out), 32'd0);
    chk("ar_gnt", 32'(bus.gnt), 32'd0);
    chk("ar_err", 32'(bus.err_timeout), 32'd0);
    chk("ar_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.req  = '0;
    stg_mode = 0;
    rst      = 1'b0;
    mptr     = 0;
    @(negedge clk);

    // Illegal dual-rail pair 11 on bit 3 of the result.
    corrupt = 16'h00C0;
`ifdef MTNCL_DR_CHECK_EN
    ed = 8'h07;
`else
    ed = 8'h0F;
`endif
    run_txn(4'b0001, 32'h0000_000F, 1, 1'b0, 4'b0001, ed, dual_rail(8'h0F));
`ifdef MTNCL_DR_CHECK_EN
    chk("dr_err", 32'(dr_err), 32'd1);
`endif
    corrupt = '0;

    // Randomized transactions against the round-robin reference model.
    for (int t = 0; t < 30; t++) begin
      rv = 4'($urandom_range(1, 15));
      dv = $urandom;
      g  = pick(rv, mptr);
      ed = dv[g*8 +: 8];
      run_txn(rv, dv, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
              4'(1 << g), ed, dual_rail(ed));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/mtncl_wave_sched.md
Name: mtncl_wave_sched

Overview:
- Synchronous scheduler that shares one MTNCL datapath stage among NREQ clocked requesters.
- Grants requesters round-robin and drives the stage's dual-rail inputs and sleep line.
- Sequences each DATA wavefront and the following NULL wavefront using the stage's completion-tree output ko, which is asynchronous and synchronized internally.
- Captures the dual-rail result and returns it as single-rail to the granted requester.

Parameters:
NREQ, 4, number of requesters (2..16)
WIDTH, 8, single-rail data width; stage rails are 2*WIDTH
SYNC_STAGES, 2, flops in the ko synchronizer (>=2)
TIMEOUT, 255, max cycles waiting on ko per phase (1..65535)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req  in  NREQ  request per requester; level, held until its done pulse
din  in  NREQ*WIDTH  single-rail operand, slice i belongs to requester i
gnt  out  NREQ  one-hot grant, held for the whole transaction
done  out  NREQ  one-cycle pulse to the granted requester when the result is valid
dout  out  WIDTH  captured single-rail result, valid with done
dr_out  out  2*WIDTH  dual-rail drive to stage; bit b: rail1=[2b+1], rail0=[2b]
sleep_out  out  1  MTNCL sleep to stage (1 = NULL/sleep)
ko_in  in  1  completion-tree output from stage, asynchronous
res_dr  in  2*WIDTH  dual-rail result rails from stage
busy  out  1  high in any state except IDLE
err_timeout  out  1  sticky timeout flag; cleared only by rst

Behaviour:
- Reset values: gnt=0, done=0, dout=0, dr_out=0, sleep_out=1, busy=0, err_timeout=0, RR pointer=0, synchronizer=0, state=IDLE.
- ko_in passes through SYNC_STAGES flops to give ko_s. All decisions use ko_s only.
- IDLE:
  - If any req and ko_s==0: grant the first asserted req at or after ptr, wrapping modulo NREQ.
  - Register gnt and latch din slice i into opreg. Go to DATA. ptr becomes i+1 mod NREQ.
  - If ko_s==1 in IDLE, wait; no grant is issued.
- DATA:
  - sleep_out=0. dr_out encodes opreg: bit=1 -> rail1=1, rail0=0; bit=0 -> rail1=0, rail0=1.
  - Timer counts from 0. When ko_s==1: latch res_dr, decoding rail1 of each pair into dout. Go to RETURN.
  - If the timer reaches TIMEOUT first: set err_timeout, dout=0, go to RETURN.
- RETURN (1 cycle): done[i]=1 and gnt stays. Next cycle go to NULL.
- NULL:
  - sleep_out=1, dr_out=0, timer restarts.
  - When ko_s==0: clear gnt and go to IDLE.
  - If TIMEOUT expires: set err_timeout, clear gnt, go to IDLE. IDLE still blocks new grants while ko_s==1.
- Minimum transaction is SYNC_STAGES+1 cycles DATA, 1 RETURN, and SYNC_STAGES+1 NULL.
- If req[i] drops while granted, the transaction still completes. done is still pulsed and is ignored by the requester.
- din changes after grant have no effect, because opreg is used.
- Simultaneous requests: the RR pointer decides. A requester that was just served has lowest priority next time.
- Reset asserted mid-transaction: all outputs return to reset values immediately (async). sleep_out=1 forces the stage to NULL.
- gnt is always one-hot or zero. done is asserted only together with gnt.

Optional Feature:
MTNCL_DR_CHECK_EN
- Defined: adds output dr_err (1 bit, reset 0, sticky).
  - At DATA capture, any res_dr pair equal to 11 or 00 sets dr_err.
  - dout for such bits is forced to 0; done is still pulsed.
- Undefined: no dr_err port. Only rail1 is decoded and no pair check is made.

Test Plan:
- Single request: NREQ=4, req=0001, din[7:0]=0xA5. Stage model returns ko 3 cycles after DATA. Expect dr_out=0x9966 during DATA, done[0] pulse, dout=0xA5, then sleep_out=1, then IDLE.
- Round-robin: req=1111 held for 4 transactions. Expect grant order 0,1,2,3. Then with req=1001, expect grants 0,3,0.
- DATA timeout: TIMEOUT=10, ko_in held 0. Expect err_timeout=1 after 10 DATA cycles, done pulse with dout=0, NULL entered, sleep_out=1.
- NULL stall: ko_in held 1 after data. Expect timeout, gnt cleared, and no new grant while ko stays 1. Release ko -> the next req is granted.
- Async reset in DATA: assert rst mid-wait. Expect same-cycle sleep_out=1, dr_out=0, gnt=0, err_timeout=0.
- With MTNCL_DR_CHECK_EN: res_dr bit pair 3 = 11 at capture. Expect dr_err=1, dout[3]=0, and the other bits correct.
